// File: rtl/mul_unit_pkg.sv
// Shared definitions for the iterative multiplier.
// Holds default widths, the iteration-count helpers and the control state encoding.
package mul_unit_pkg;

    localparam int unsigned REG_ADDRESS_SIZE_DEF = 5;
    localparam int unsigned REG_SIZE_DEF         = 32;
    localparam int unsigned STEP_BITS_DEF        = 2;

    // Number of shift-add iterations for a given operand width and radix.
    function automatic int unsigned iter_count(input int unsigned reg_size,
                                               input int unsigned step_bits);
        return reg_size / step_bits;
    endfunction

    // Counter width able to hold 0..iters-1 (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned iters);
        return (iters > 1) ? $clog2(iters) : 1;
    endfunction

    localparam int unsigned N_ITER = iter_count(REG_SIZE_DEF, STEP_BITS_DEF);
    localparam int unsigned CNT_W  = cnt_width(N_ITER);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mul_unit_step.sv
// Combinational partial-product adder for one multiplier digit.
// Ports:
//   acc        current accumulator
//   mcand      multiplicand, already shifted to this digit's weight
//   digit      STEP_BITS-wide slice of the multiplier
//   acc_next_c acc + mcand * digit, truncated to REG_SIZE
module mul_unit_step #(
    parameter int unsigned REG_SIZE  = 32,
    parameter int unsigned STEP_BITS = 2
) (
    input  logic [REG_SIZE-1:0]  acc,
    input  logic [REG_SIZE-1:0]  mcand,
    input  logic [STEP_BITS-1:0] digit,
    output logic [REG_SIZE-1:0]  acc_next_c
);

    // Sum the shifted multiplicand once per set digit bit.
    always_comb begin
        acc_next_c = acc;
        for (int unsigned i = 0; i < STEP_BITS; i++) begin
            if (digit[i]) begin
                acc_next_c = acc_next_c + (mcand << i);
            end
        end
    end

endmodule

// File: rtl/mul_unit.sv
// Iterative shift-add multiplier stage between decode and register write-back.
// Ports:
//   clk, reset     clock; asynchronous active-high reset
//   MUL_valid      decode issues a multiply (sampled only when idle)
//   MUL_operand1   multiplicand
//   MUL_operand2   multiplier
//   MUL_dest       destination register
//   MUL_w          instruction writes a register
//   MUL_wb_grant   write-back port accepts the result
//   MUL_stall      unit busy or holding an unwritten result
//   MUL_result     low REG_SIZE bits of the product
//   MUL_Wat        write-back register address
//   MUL_We         write-back request
module mul_unit
    import mul_unit_pkg::*;
#(
    parameter int unsigned REG_ADDRESS_SIZE = REG_ADDRESS_SIZE_DEF,
    parameter int unsigned REG_SIZE         = REG_SIZE_DEF,
    parameter int unsigned STEP_BITS        = STEP_BITS_DEF
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        MUL_valid,
    input  logic [REG_SIZE-1:0]         MUL_operand1,
    input  logic [REG_SIZE-1:0]         MUL_operand2,
    input  logic [REG_ADDRESS_SIZE-1:0] MUL_dest,
    input  logic                        MUL_w,
    input  logic                        MUL_wb_grant,
    output logic                        MUL_stall,
    output logic [REG_SIZE-1:0]         MUL_result,
    output logic [REG_ADDRESS_SIZE-1:0] MUL_Wat,
    output logic                        MUL_We
);

    localparam int unsigned ITERS = iter_count(REG_SIZE, STEP_BITS);
    localparam int unsigned CW    = cnt_width(ITERS);

    state_t                      state, state_n;
    logic [REG_SIZE-1:0]         acc, acc_n;
    logic [REG_SIZE-1:0]         mcand, mcand_n;
    logic [REG_SIZE-1:0]         mplier, mplier_n;
    logic [CW-1:0]               count, count_n;
    logic [REG_ADDRESS_SIZE-1:0] dest, dest_n;
    logic                        w, w_n;
    logic                        stall_q, stall_n;
    logic                        we_q, we_n;
    logic [REG_SIZE-1:0]         step_acc_c;

    mul_unit_step #(
        .REG_SIZE  (REG_SIZE),
        .STEP_BITS (STEP_BITS)
    ) u_step (
        .acc        (acc),
        .mcand      (mcand),
        .digit      (mplier[STEP_BITS-1:0]),
        .acc_next_c (step_acc_c)
    );

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            count   <= '0;
            dest    <= '0;
            w       <= 1'b0;
            stall_q <= 1'b0;
            we_q    <= 1'b0;
        end else begin
            state   <= state_n;
            acc     <= acc_n;
            mcand   <= mcand_n;
            mplier  <= mplier_n;
            count   <= count_n;
            dest    <= dest_n;
            w       <= w_n;
            stall_q <= stall_n;
            we_q    <= we_n;
        end
    end

    // Next-state, datapath update and registered-output precompute.
    always_comb begin
        state_n  = state;
        acc_n    = acc;
        mcand_n  = mcand;
        mplier_n = mplier;
        count_n  = count;
        dest_n   = dest;
        w_n      = w;

        case (state)
            IDLE: begin
                if (MUL_valid) begin
                    acc_n    = '0;
                    mcand_n  = MUL_operand1;
                    mplier_n = MUL_operand2;
                    count_n  = '0;
                    dest_n   = MUL_dest;
                    w_n      = MUL_w;
                    state_n  = BUSY;
                end
            end
            BUSY: begin
                acc_n    = step_acc_c;
                mcand_n  = mcand << STEP_BITS;
                mplier_n = mplier >> STEP_BITS;
                count_n  = count + CW'(1);
                if (count == CW'(ITERS - 1)) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                // Ops that do not write retire after a single DONE cycle.
                if (MUL_wb_grant || !w) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Outputs are registered copies of what the next state implies.
        stall_n = (state_n != IDLE);
        we_n    = (state_n == DONE) && w_n;
    end

    assign MUL_stall  = stall_q;
    assign MUL_We     = we_q;
    assign MUL_result = acc;
    assign MUL_Wat    = dest;

endmodule

// File: doc/mul_unit.md
# mul_unit

Iterative multi-cycle integer multiplier, the execution stage directly downstream of decode for multiply instructions. Accepts operands, destination and write flag from decode when decode selects the multiplier, computes the low REG_SIZE bits of the product over a fixed number of cycles, and presents the result to the register-bank write port. Drives the multiplier stall back to decode while an operation is in flight or its result is still unwritten.

## Interface
- REG_ADDRESS_SIZE, 5, register address width
- REG_SIZE, 32, operand/result width
- STEP_BITS, 2, multiplier bits consumed per cycle; must divide REG_SIZE

- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- MUL_valid  in  1  decode issues a multiply this cycle (decode use_mul and not stalled)
- MUL_operand1  in  REG_SIZE  multiplicand
- MUL_operand2  in  REG_SIZE  multiplier (register or immediate, already muxed by decode)
- MUL_dest  in  REG_ADDRESS_SIZE  destination register
- MUL_w  in  1  instruction writes a register
- MUL_wb_grant  in  1  write-back port accepts the result this cycle
- MUL_stall  out  1  to decode; multiplier cannot accept a new op
- MUL_result  out  REG_SIZE  product, low REG_SIZE bits
- MUL_Wat  out  REG_ADDRESS_SIZE  write-back register address
- MUL_We  out  1  write-back request

## Operation
- N = REG_SIZE/STEP_BITS iterations (16 at defaults).
- States: IDLE, BUSY, DONE.
- IDLE: MUL_stall=0, MUL_We=0. On MUL_valid: latch mcand=operand1, mplier=operand2, acc=0, dest, w; count=0; go BUSY.
- BUSY: MUL_stall=1. Each cycle acc += mcand * mplier[STEP_BITS-1:0] (truncated to REG_SIZE); mcand <<= STEP_BITS; mplier >>= STEP_BITS; count++. When count==N-1 (last add performed this cycle) go DONE.
- DONE: MUL_stall=1, MUL_result=acc, MUL_Wat=dest, MUL_We=w. Leave to IDLE when MUL_wb_grant=1 or w=0; otherwise hold all outputs stable.
- Arithmetic: unsigned shift-add; low half identical for two's-complement operands, so signed and unsigned multiplies share the unit. Overflow bits discarded.
- MUL_valid outside IDLE is ignored (decode is stalled by contract); no state change.
- MUL_result and MUL_Wat are don't-care outside DONE but must be driven from registers (no X propagation); MUL_We=0 outside DONE.
- Reset: state=IDLE, acc=0, count=0, dest=0, w=0; outputs MUL_stall=0, MUL_We=0, MUL_result=0, MUL_Wat=0. Reset mid-BUSY or mid-DONE aborts the op with no write.

## Timing
- Issue at edge k (MUL_valid=1 in IDLE): MUL_stall high from cycle k+1.
- BUSY occupies cycles k+1..k+N; DONE visible from cycle k+N+1.
- Granted in first DONE cycle: IDLE and MUL_stall=0 at cycle k+N+2; minimum op-to-op issue interval N+2 cycles.
- Grant withheld g cycles: DONE extends by g; result, address, We unchanged throughout.
- w=0: DONE lasts exactly one cycle regardless of grant, MUL_We=0.
- MUL_stall is registered-state-derived (state != IDLE); no combinational path from MUL_valid to MUL_stall.

## Structure
- Shared package: state enum (IDLE/BUSY/DONE), iteration-count constant N and count width $clog2(N).
- One sub-module natural: mul_step, combinational partial-product adder (acc, mcand, mplier digit -> next acc); keeps radix change local to STEP_BITS.

## Test plan
- 7 * 6 issued, w=1, dest=3, grant tied high -> MUL_We=1, MUL_Wat=3, MUL_result=42 at cycle k+17; MUL_stall=1 for cycles k+1..k+17, 0 at k+18.
- 0xFFFFFFFF * 0xFFFFFFFF (-1*-1) -> result 0x00000001; 0x80000000 * 2 -> 0x00000000 (overflow discarded).
- Grant held low 5 cycles in DONE, operands 123*456 -> result 56088 and We stable for 6 cycles, IDLE the cycle after grant.
- w=0, 5*5, grant low -> one DONE cycle with MUL_We=0, back to IDLE at k+18.
- Reset asserted asynchronously mid-BUSY (cycle k+8) -> MUL_stall and MUL_We drop immediately; after release, new op 3*3 completes with result 9, no stale write.
- MUL_valid pulsed with different operands during BUSY -> ignored; original product delivered unchanged.
